// File: rtl/stream_frame_sequencer.sv
// stream_frame_sequencer
//   Gates the sample stream from the IO pins into the spectrometer input,
//   cuts it into frames of programmable length (m_last), supports continuous
//   and single-shot capture, counts frames and raises a level interrupt.
//
// Ports
//   wb_clk_i / wb_rst_i          clock, synchronous active-high reset
//   wbs_*                        Wishbone classic slave (adr[3:2] decoded)
//                                  0x0 CTRL       [0] ENABLE [1] ONESHOT(W1S, reads 0)
//                                                 [2] IRQ_EN [3] DROP_IDLE
//                                  0x4 FRAME_LEN  [LEN_W-1:0] (0 behaves as 1)
//                                  0x8 STATUS     [0] BUSY [1] IRQ_PEND(W1C) [31:16] FRAME_CNT
//                                  0xC SAMPLE_CNT [LEN_W-1:0]
//   s_valid/s_data/s_ready       sample input from pins
//   m_valid/m_data/m_last/m_ready stream to spectrometer (zero latency)
//   irq                          IRQ_PEND & IRQ_EN
module stream_frame_sequencer #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 10,
  parameter int LEN_RST = 512
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state, state_nxt;
  logic             ctrl_en, irq_en, drop_idle, single;
  logic [LEN_W-1:0] frame_len, len_shadow, len_eff, sample_cnt, cnt_nxt;
  logic [15:0]      frame_cnt;
  logic             irq_pend;
  logic             busy, beat, at_end, last_beat;
  logic [31:0]      wmask, rdata;

  // Register writes commit at the end of the ack cycle, so a CTRL write
  // becomes visible the cycle after ack.
  logic       wb_req, wb_wr;
  logic [1:0] reg_sel;
  logic       ctrl_wr, len_wr, stat_wr, start, en_off;

  assign wb_req  = wbs_cyc_i & wbs_stb_i;
  assign wb_wr   = wbs_ack_o & wb_req & wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign ctrl_wr = wb_wr & (reg_sel == 2'd0) & wbs_sel_i[0];
  assign len_wr  = wb_wr & (reg_sel == 2'd1);
  assign stat_wr = wb_wr & (reg_sel == 2'd2) & wbs_sel_i[0];
  assign start   = ctrl_wr & (wbs_dat_i[0] | wbs_dat_i[1]);
  // Only a falling ENABLE stops a run; single-shot runs have ENABLE=0.
  assign en_off  = ctrl_wr & ctrl_en & ~wbs_dat_i[0];

  always_comb begin
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wbs_sel_i[i]}};
  end

  // Datapath
  assign busy      = (state != IDLE);
  assign m_data    = s_data;
  assign m_valid   = s_valid & busy;
  assign s_ready   = busy ? m_ready : drop_idle;
  assign beat      = m_valid & m_ready;
  assign len_eff   = (len_shadow == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : len_shadow;
  assign at_end    = (sample_cnt == len_eff - 1'b1);
  assign m_last    = m_valid & at_end;
  assign last_beat = beat & at_end;
  assign irq       = irq_pend & irq_en;

  always_comb begin
    cnt_nxt = sample_cnt;
    if (last_beat)  cnt_nxt = '0;
    else if (beat)  cnt_nxt = sample_cnt + 1'b1;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (last_beat && single) state_nxt = IDLE;
        // Judge against the post-beat count so a coinciding last beat ends idle.
        else if (en_off)         state_nxt = (cnt_nxt == '0) ? IDLE : STOP;
      end
      STOP: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: begin
        rdata[0] = ctrl_en;
        rdata[2] = irq_en;
        rdata[3] = drop_idle;
      end
      2'd1: rdata[LEN_W-1:0] = frame_len;
      2'd2: begin
        rdata[0]     = busy;
        rdata[1]     = irq_pend;
        rdata[31:16] = frame_cnt;
      end
      default: rdata[LEN_W-1:0] = sample_cnt;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ctrl_en    <= 1'b0;
      irq_en     <= 1'b0;
      drop_idle  <= 1'b0;
      single     <= 1'b0;
      frame_len  <= LEN_W'(LEN_RST);
      len_shadow <= LEN_W'(LEN_RST);
      sample_cnt <= '0;
      frame_cnt  <= '0;
      irq_pend   <= 1'b0;
    end else begin
      state <= state_nxt;

      // One-cycle ack, never back-to-back; data only alongside ack.
      wbs_ack_o <= wb_req & ~wbs_ack_o;
      wbs_dat_o <= (wb_req & ~wbs_ack_o) ? rdata : '0;

      if (ctrl_wr) begin
        ctrl_en   <= wbs_dat_i[0];
        irq_en    <= wbs_dat_i[2];
        drop_idle <= wbs_dat_i[3];
      end
      if (state == IDLE && start) single <= ~wbs_dat_i[0];

      if (len_wr)
        frame_len <= (frame_len & ~wmask[LEN_W-1:0]) | (wbs_dat_i[LEN_W-1:0] & wmask[LEN_W-1:0]);

      sample_cnt <= cnt_nxt;
      // Shadow length only reloads between frames.
      if ((state == IDLE && sample_cnt == '0) || last_beat) len_shadow <= frame_len;

      if (last_beat) begin
        frame_cnt <= frame_cnt + 16'd1;
        irq_pend  <= 1'b1;
      end else if (stat_wr && wbs_dat_i[1]) begin
        irq_pend  <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0],
                         wbs_dat_i[31:LEN_W], wmask[31:LEN_W]};

endmodule

// File: tb/tb_stream_frame_sequencer.sv
module tb_stream_frame_sequencer;
  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        s_valid = 1'b0, s_ready, m_valid, m_last, m_ready = 1'b0, irq;
  logic [7:0]  s_data = 8'h00, m_data;

  int total = 0, bad = 0;

  stream_frame_sequencer #(.DATA_W(8), .LEN_W(10), .LEN_RST(512)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Starts and ends at posedge+1.
  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = sel;
    n = 0;
    do begin @(posedge wb_clk_i); #1; n++; end while (!wbs_ack_o && n < 8);
    chk("wb_ack_latency", 32'(n), 32'd1);
    rd = wbs_dat_o;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    chk1("wb_no_b2b_ack", wbs_ack_o, 1'b0);
    chk("wb_dat_idle", wbs_dat_o, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, sel, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
    chk(tag, rd, exp);
  endtask

  task automatic stream(input string tag, input logic v, input logic [7:0] d, input logic rdy,
                        input logic e_mv, input logic e_last, input logic e_srdy);
    s_valid = v; s_data = d; m_ready = rdy;
    #1;
    chk1({tag, "/m_valid"}, m_valid, e_mv);
    chk1({tag, "/m_last"},  m_last,  e_last);
    chk1({tag, "/s_ready"}, s_ready, e_srdy);
    chk({tag, "/m_data"}, {24'd0, m_data}, {24'd0, d});
    @(posedge wb_clk_i); #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; m_ready = 1'b0;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
  endtask

  localparam logic [31:0] A_CTRL = 32'h0, A_LEN = 32'h4, A_STAT = 32'h8, A_CNT = 32'hC;

  initial begin
    logic [13:0] lmap;
    logic [7:0]  k;
    int          b;

    // Reset state
    do_reset();
    chk1("rst_ack", wbs_ack_o, 1'b0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk1("rst_irq", irq, 1'b0);
    stream("rst_gate", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    s_valid = 1'b0;
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_len",  A_LEN,  32'h200);
    rd_chk("rst_stat", A_STAT, 32'h0);
    rd_chk("rst_cnt",  A_CNT,  32'h0);
    wr(A_LEN, 32'h0000_03FF, 4'h1);  // only byte 0 lands
    rd_chk("len_bytelane", A_LEN, 32'h2FF);

    // Continuous capture, L=4
    do_reset();
    wr(A_LEN, 32'd4);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 10; i++)
      stream("cont", 1'b1, 8'(i), 1'b1, 1'b1, (i == 3 || i == 7), 1'b1);
    s_valid = 1'b0;
    rd_chk("cont_stat", A_STAT, 32'h0002_0003);
    rd_chk("cont_cnt", A_CNT, 32'd2);
    chk1("cont_irq_masked", irq, 1'b0);

    // Single shot, L=3, IRQ_EN
    do_reset();
    wr(A_LEN, 32'd3);
    wr(A_CTRL, 32'h6);
    for (int i = 0; i < 6; i++)
      stream("shot", 1'b1, 8'(8'h20 + i), 1'b1, (i < 3), (i == 2), (i < 3));
    s_valid = 1'b0;
    chk1("shot_irq", irq, 1'b1);
    rd_chk("shot_stat", A_STAT, 32'h0001_0002);
    rd_chk("shot_ctrl_reads", A_CTRL, 32'h4);
    wr(A_STAT, 32'h2);
    chk1("shot_irq_clr", irq, 1'b0);

    // Stop mid-frame, L=8
    do_reset();
    wr(A_LEN, 32'd8);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) stream("stop_a", 1'b1, 8'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    s_valid = 1'b0;
    wr(A_CTRL, 32'h0);
    rd_chk("stop_busy", A_STAT, 32'h0000_0001);
    for (int i = 3; i < 8; i++) stream("stop_b", 1'b1, 8'(i), 1'b1, 1'b1, (i == 7), 1'b1);
    stream("stop_after", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    s_valid = 1'b0;
    rd_chk("stop_stat", A_STAT, 32'h0001_0002);

    // Backpressure then drop-idle, L=4
    do_reset();
    wr(A_LEN, 32'd4);
    wr(A_CTRL, 32'h1);
    k = 8'h40; b = 0;
    for (int i = 0; i < 8; i++) begin
      stream("bp", 1'b1, k, i[0], 1'b1, (b % 4 == 3), i[0]);
      if (i[0]) begin k++; b++; end
    end
    s_valid = 1'b0;
    rd_chk("bp_stat", A_STAT, 32'h0001_0003);
    rd_chk("bp_cnt", A_CNT, 32'd0);
    wr(A_CTRL, 32'h8);
    stream("drop", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    s_valid = 1'b0;
    rd_chk("drop_stat", A_STAT, 32'h0001_0002);

    // FRAME_LEN changes mid-frame: 5, then 2, 2, 2, then L=0 behaves as 1
    do_reset();
    wr(A_LEN, 32'd5);
    wr(A_CTRL, 32'h1);
    lmap = 14'b11110101010000;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin s_valid = 1'b0; wr(A_LEN, 32'd2); end
      if (i == 9) begin s_valid = 1'b0; wr(A_LEN, 32'd0); end
      stream("flen", 1'b1, 8'(8'h60 + i), 1'b1, 1'b1, lmap[i], 1'b1);
    end
    s_valid = 1'b0;
    rd_chk("flen_stat", A_STAT, 32'h0007_0003);
    rd_chk("flen_cnt", A_CNT, 32'd0);

    // Reset mid-frame
    do_reset();
    wr(A_LEN, 32'd4);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 6; i++) stream("mrst", 1'b1, 8'(i), 1'b1, 1'b1, (i == 3), 1'b1);
    chk1("mrst_irq_pre", irq, 1'b1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    chk1("mrst_m_valid", m_valid, 1'b0);
    chk1("mrst_m_last", m_last, 1'b0);
    chk1("mrst_s_ready", s_ready, 1'b0);
    chk1("mrst_irq", irq, 1'b0);
    chk1("mrst_ack", wbs_ack_o, 1'b0);
    chk("mrst_dat", wbs_dat_o, 32'd0);
    s_valid = 1'b0;
    rd_chk("mrst_cnt", A_CNT, 32'd0);
    rd_chk("mrst_len", A_LEN, 32'h200);
    rd_chk("mrst_stat", A_STAT, 32'h0);
    rd_chk("mrst_ctrl", A_CTRL, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
